serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 1..32.
REQ-002 Port: CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: RST_N  input  1  asynchronous, active-low reset.
REQ-004 Port: START  input  1  request a new addition; sampled on the rising edge of CLK.
REQ-005 Port: A  input  WIDTH  operand A; captured when START is accepted.
REQ-006 Port: B  input  WIDTH  operand B; captured when START is accepted.
REQ-007 Port: CI  input  1  carry-in; captured when START is accepted.
REQ-008 Port: SUM  output  WIDTH  registered result of A+B+CI, modulo 2^WIDTH.
REQ-009 Port: CO  output  1  registered carry-out of the MSB.
REQ-010 Port: OVF  output  1  registered two's-complement overflow (carry into MSB XOR carry out of MSB).
REQ-011 Port: BUSY  output  1  high while an addition is in progress.
REQ-012 Port: DONE  output  1  one-cycle pulse; result is valid on the same cycle.

Function
REQ-013 The block SHALL compute A+B+CI bit-serially, LSB first, using exactly one single-bit full-adder cell (sum = a^b^c, carry = ab|ac|bc) and one carry register.
REQ-014 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-015 In IDLE or FIN, START=1 SHALL be accepted: A, B and CI are loaded into internal shift/carry registers, the bit counter is cleared to 0, and the next state is RUN.
REQ-016 In RUN, each edge SHALL process one bit: carry register <= full-adder carry, result shift register receives the sum bit, operand registers shift right by one, and the counter increments.
REQ-017 When the counter equals WIDTH-1 in RUN, the next state SHALL be FIN, and SUM, CO and OVF SHALL be updated on that same edge.
REQ-018 Latency: with START accepted at edge 0, DONE=1 SHALL occur in the cycle following edge WIDTH; the sequence is exactly WIDTH RUN cycles.
REQ-019 In FIN without START, the next state SHALL be IDLE; DONE SHALL be high only in FIN.
REQ-020 BUSY SHALL be 1 only in RUN; DONE and BUSY SHALL never both be 1.
REQ-021 START while in RUN SHALL be ignored; in-flight operands and the result SHALL NOT be disturbed.
REQ-022 A, B and CI SHALL be don't-care except on the accepting edge.
REQ-023 SUM, CO and OVF SHALL hold their last values until the next REQ-017 update, including across IDLE periods and a new accepted START.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation; for WIDTH=1, RUN SHALL last one cycle.
REQ-025 Back-to-back operation: START in FIN SHALL go directly to RUN, giving one result every WIDTH+1 cycles.

Reset
REQ-026 RST_N=0 SHALL immediately force: state IDLE, SUM=0, CO=0, OVF=0, BUSY=0, DONE=0, and counter, carry and shift registers all 0.
REQ-027 Reset asserted during RUN SHALL abort the operation with no DONE pulse; the first START after RST_N deasserts SHALL start a fresh operation.
REQ-028 After reset deassertion, outputs SHALL stay at reset values until the first REQ-017 update.

Verification (WIDTH=8)
REQ-029 A=0x5A, B=0x3C, CI=0, START for 1 cycle -> BUSY high for 8 cycles, then DONE pulse with SUM=0x96, CO=0, OVF=1.
REQ-030 A=0xFF, B=0x01, CI=0 -> SUM=0x00, CO=1, OVF=0; A=0x7F, B=0x00, CI=1 -> SUM=0x80, CO=0, OVF=1.
REQ-031 A=0x10, B=0x20 started; at RUN cycle 3, START with A=0xFF, B=0xFF -> ignored; DONE with SUM=0x30, CO=0; no second DONE pulse.
REQ-032 RST_N pulsed low at RUN cycle 4 -> all outputs 0 asynchronously, no DONE; a new START with A=0x01, B=0x01 -> SUM=0x02 after 8 RUN cycles.
REQ-033 START held high continuously with A=0x03, B=0x04, CI=0 -> DONE every 9 cycles, SUM=0x07 each time; never BUSY=1 and DONE=1 together.
REQ-034 Randomised check: 1000 random A, B, CI against a reference model of SUM, CO and OVF, repeated for WIDTH=1 and WIDTH=32.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//
// Bit-serial adder with its own controller. It computes A + B + CI modulo
// 2^WIDTH, least significant bit first. One single-bit full-adder cell and
// one carry flop are shared across all bit positions.
//
// A request is accepted in the idle state or the finish state. The accepting
// edge loads the operands and the carry-in. After that, each run cycle
// consumes one operand bit. The last run edge loads SUM, CO and OVF and moves
// the controller to the finish state, where DONE pulses for one cycle.
// Results hold their value until the next operation completes.
//
// Parameters
//   WIDTH  operand/result width in bits, legal range 1..32
//
// Ports
//   CLK    clock, rising-edge active
//   RST_N  asynchronous active-low reset
//   START  start request, sampled on the rising edge of CLK (ignored while BUSY)
//   A, B   operands, captured on the accepting edge only
//   CI     carry-in, captured on the accepting edge only
//   SUM    registered sum, A + B + CI modulo 2^WIDTH
//   CO     registered carry out of the MSB
//   OVF    registered two's-complement overflow
//   BUSY   high while bits are being processed
//   DONE   one-cycle pulse; SUM/CO/OVF are valid in this cycle

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic [WIDTH-1:0] SUM,
    output logic             CO,
    output logic             OVF,
    output logic             BUSY,
    output logic             DONE
);

    // The counter counts from 0 to WIDTH-1 and never wraps within an operation.
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    // Single shared full-adder cell working on the current bit position.
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] res_shift;
    logic             load;

    always_comb begin
        fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
        fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        // Each new sum bit enters at the MSB. After WIDTH shifts, the first
        // bit computed has moved down to bit 0.
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = fa_sum;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                load = START;
            end
            StFin: begin
                // Going straight from the finish state to run gives one result
                // every WIDTH+1 cycles.
                load    = START;
                state_d = StIdle;
            end
            StRun: begin
                carry_d = fa_carry;
                res_d   = res_shift;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    state_d = StFin;
                    sum_d   = res_shift;
                    co_d    = fa_carry;
                    // carry_q is the carry into the MSB on this final bit.
                    ovf_d   = carry_q ^ fa_carry;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            state_d = StRun;
            a_d     = A;
            b_d     = B;
            carry_d = CI;
            cnt_d   = '0;
            res_d   = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign SUM  = sum_q;
    assign CO   = co_q;
    assign OVF  = ovf_q;
    assign BUSY = (state_q == StRun);
    assign DONE = (state_q == StFin);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl. It drives three instances (WIDTH = 8, 1, 32)
// from a shared clock and reset. Results are checked against a fixed vector
// table, hand-written corner sequences, and a plain-arithmetic reference model.

module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start8, ci8, co8, ovf8, busy8, done8;
    logic [7:0] a8, b8, sum8;

    logic       start1, ci1, co1, ovf1, busy1, done1;
    logic [0:0] a1, b1, sum1;

    logic        start32, ci32, co32, ovf32, busy32, done32;
    logic [31:0] a32, b32, sum32;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8), .CI(ci8),
        .SUM(sum8), .CO(co8), .OVF(ovf8), .BUSY(busy8), .DONE(done8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .A(a1), .B(b1), .CI(ci1),
        .SUM(sum1), .CO(co1), .OVF(ovf1), .BUSY(busy1), .DONE(done1)
    );

    serial_add_ctrl #(.WIDTH(32)) u_dut32 (
        .CLK(clk), .RST_N(rst_n), .START(start32), .A(a32), .B(b32), .CI(ci32),
        .SUM(sum32), .CO(co32), .OVF(ovf32), .BUSY(busy32), .DONE(done32)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] sum;
        logic       co;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // BUSY and DONE must never be high together on any instance.
    always @(negedge clk) begin
        if ((busy8 && done8) || (busy1 && done1) || (busy32 && done32)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_done_overlap: got both high at %0t, expected exclusive", $time);
        end
    end

    // Reference: plain integer arithmetic on the operand values.
    function automatic void ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic ci, output logic [31:0] s,
                                    output logic co, output logic ovf);
        longint m, ua, ub, full, half, sa, sb, r;
        m    = (longint'(1) << w) - 1;
        ua   = {32'b0, a} & m;
        ub   = {32'b0, b} & m;
        full = ua + ub + {63'b0, ci};
        s    = 32'(full & m);
        co   = 1'((full >> w) & 1);
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - (half << 1) : ua;
        sb   = (ub >= half) ? ub - (half << 1) : ub;
        r    = sa + sb + {63'b0, ci};
        ovf  = (r >= half) || (r < -half);
    endfunction

    task automatic drive(input int inst, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input logic ci);
        case (inst)
            1:  begin start1  = st; a1  = a[0:0]; b1  = b[0:0]; ci1  = ci; end
            32: begin start32 = st; a32 = a;      b32 = b;      ci32 = ci; end
            default: begin start8 = st; a8 = a[7:0]; b8 = b[7:0]; ci8 = ci; end
        endcase
    endtask

    function automatic logic get_done(input int inst);
        case (inst)
            1:       return done1;
            32:      return done32;
            default: return done8;
        endcase
    endfunction

    function automatic logic get_busy(input int inst);
        case (inst)
            1:       return busy1;
            32:      return busy32;
            default: return busy8;
        endcase
    endfunction

    function automatic logic [31:0] get_sum(input int inst);
        case (inst)
            1:       return {31'b0, sum1};
            32:      return sum32;
            default: return {24'b0, sum8};
        endcase
    endfunction

    function automatic logic get_co(input int inst);
        case (inst)
            1:       return co1;
            32:      return co32;
            default: return co8;
        endcase
    endfunction

    function automatic logic get_ovf(input int inst);
        case (inst)
            1:       return ovf1;
            32:      return ovf32;
            default: return ovf8;
        endcase
    endfunction

    // One complete operation. Operands are scrambled after the accepting
    // edge, so any late sampling of A/B/CI shows up as a wrong result.
    task automatic do_op(input int inst, input int w, input logic [31:0] a,
                         input logic [31:0] b, input logic ci, input logic [31:0] es,
                         input logic eco, input logic eovf, input string tag);
        int busy_n;
        bit got;
        @(posedge clk); #1 drive(inst, 1'b1, a, b, ci);
        @(posedge clk); #1 drive(inst, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
        busy_n = 0;
        got    = 1'b0;
        for (int i = 0; i < w + 4 && !got; i++) begin
            @(negedge clk);
            if (get_done(inst)) got = 1'b1;
            else if (get_busy(inst)) busy_n++;
        end
        check({tag, "_done_seen"}, {31'b0, got}, 32'd1);
        check({tag, "_busy_cycles"}, busy_n, w);
        check({tag, "_sum"}, get_sum(inst), es);
        check({tag, "_co"}, {31'b0, get_co(inst)}, {31'b0, eco});
        check({tag, "_ovf"}, {31'b0, get_ovf(inst)}, {31'b0, eovf});
    endtask

    task automatic rand_op(input int inst, input int w, input string tag);
        logic [31:0] a, b, es;
        logic ci, eco, eovf;
        a  = $urandom;
        b  = $urandom;
        ci = 1'($urandom_range(0, 1));
        ref_add(w, a, b, ci, es, eco, eovf);
        do_op(inst, w, a, b, ci, es, eco, eovf, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int insts[3];
        int dones;
        int last;
        logic [7:0] first_sum;
        logic first_co;

        insts = '{8, 1, 32};
        vecs[0] = '{a: 8'h5A, b: 8'h3C, ci: 1'b0, sum: 8'h96, co: 1'b0, ovf: 1'b1};
        vecs[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, sum: 8'h00, co: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h00, ci: 1'b1, sum: 8'h80, co: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, ci: 1'b0, sum: 8'h00, co: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, ci: 1'b0, sum: 8'h00, co: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, sum: 8'hFF, co: 1'b1, ovf: 1'b0};
        vecs[6] = '{a: 8'h7F, b: 8'h01, ci: 1'b0, sum: 8'h80, co: 1'b0, ovf: 1'b1};
        vecs[7] = '{a: 8'h01, b: 8'h01, ci: 1'b0, sum: 8'h02, co: 1'b0, ovf: 1'b0};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) drive(insts[k], 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_sum_w%0d", insts[k]), get_sum(insts[k]), 32'h0);
            check($sformatf("reset_flags_w%0d", insts[k]),
                  {27'b0, get_co(insts[k]), get_ovf(insts[k]), get_busy(insts[k]),
                   get_done(insts[k]), 1'b0}, 32'h0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_sum", {24'b0, sum8}, 32'h0);
        check("post_reset_flags", {28'b0, co8, ovf8, busy8, done8}, 32'h0);

        // Directed vector table.
        foreach (vecs[i]) begin
            do_op(8, 8, {24'b0, vecs[i].a}, {24'b0, vecs[i].b}, vecs[i].ci,
                  {24'b0, vecs[i].sum}, vecs[i].co, vecs[i].ovf, $sformatf("vec%0d", i));
        end

        // START during RUN is ignored; the previous result holds while running.
        @(posedge clk); #1 drive(8, 1'b1, 32'h10, 32'h20, 1'b0);
        @(posedge clk); #1 drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("hold_sum_during_run", {24'b0, sum8}, 32'h02);
        @(posedge clk);
        @(posedge clk); #1 drive(8, 1'b1, 32'hFF, 32'hFF, 1'b1);
        @(posedge clk); #1 drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
        dones     = 0;
        first_sum = 8'h00;
        first_co  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) begin
                if (dones == 0) begin
                    first_sum = sum8;
                    first_co  = co8;
                end
                dones++;
            end
        end
        check("ignore_start_done_count", dones, 1);
        check("ignore_start_sum", {24'b0, first_sum}, 32'h30);
        check("ignore_start_co", {31'b0, first_co}, 32'h0);

        // Asynchronous reset in the middle of RUN.
        @(posedge clk); #1 drive(8, 1'b1, 32'h0F, 32'h0F, 1'b0);
        @(posedge clk); #1 drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_sum", {24'b0, sum8}, 32'h0);
        check("async_reset_flags", {28'b0, co8, ovf8, busy8, done8}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) dones++;
        end
        check("no_done_after_abort", dones, 0);
        do_op(8, 8, 32'h01, 32'h01, 1'b0, 32'h02, 1'b0, 1'b0, "after_reset");

        // START held high: one result every WIDTH+1 cycles.
        @(posedge clk); #1 drive(8, 1'b1, 32'h03, 32'h04, 1'b0);
        dones = 0;
        last  = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done8) begin
                check($sformatf("b2b_sum%0d", dones), {24'b0, sum8}, 32'h07);
                if (last >= 0) check($sformatf("b2b_period%0d", dones), i - last, 9);
                last = i;
                dones++;
            end
        end
        check("b2b_done_count", dones, 6);
        #1 drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (12) @(posedge clk);

        // Randomised operations against the reference model.
        for (int i = 0; i < 200; i++) rand_op(8, 8, $sformatf("rnd8_%0d", i));
        for (int i = 0; i < 1000; i++) rand_op(1, 1, $sformatf("rnd1_%0d", i));
        for (int i = 0; i < 1000; i++) rand_op(32, 32, $sformatf("rnd32_%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
